seg7_scan_capture: RTL

- Receive-side counterpart of the team's hex-to-7-segment segment decoders.
- Monitors a time-multiplexed, active-low 7-segment display bus: one-hot active-low digit enables plus shared segment lines.
- Converts each lit pattern back to its 4-bit hex value, debounced per digit.
- Used as a loop-back checker and readback path for the display driver chain.

---
 rtl/seg7_scan_capture.sv | 90 +++++++++
 1 files changed

// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: debounced readback of a multiplexed active-low 7-segment bus into committed hex digits, with a change pulse and a sticky enable-collision flag
module seg7_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an_n,
  input  logic [6:0]              seg,
  input  logic                    clr_err,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_vld,
  output logic                    upd,
  output logic [2:0]              upd_idx,
  output logic                    err
);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);
  logic [6:0] cand [NUM_DIGITS];
  logic [3:0] cnt  [NUM_DIGITS];
  logic [3:0] low_cnt;
  logic [IW-1:0] sel;
  logic one_hot, multi, match, legal, commit, chg;
  logic [3:0] hex, nxt_cnt, cur_hex;
  always_comb begin
    low_cnt = '0;
    sel = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (!an_n[i]) begin
        low_cnt = low_cnt + 4'd1;
        sel = IW'(i);
      end
  end
  assign one_hot = low_cnt == 4'd1;
  assign multi   = low_cnt > 4'd1;
  always_comb begin
    legal = 1'b1;
    hex = 4'h0;
    case (seg)
      7'h40: hex = 4'h0;
      7'h79: hex = 4'h1;
      7'h24: hex = 4'h2;
      7'h30: hex = 4'h3;
      7'h19: hex = 4'h4;
      7'h12: hex = 4'h5;
      7'h02: hex = 4'h6;
      7'h78: hex = 4'h7;
      7'h00: hex = 4'h8;
      7'h10: hex = 4'h9;
      7'h08: hex = 4'hA;
      7'h03: hex = 4'hB;
      7'h46: hex = 4'hC;
      7'h21: hex = 4'hD;
      7'h06: hex = 4'hE;
      7'h0E: hex = 4'hF;
      default: legal = 1'b0;
    endcase
  end
  // an illegal commit keeps the old nibble, so only the valid bit can change
  assign match   = seg == cand[sel];
  assign nxt_cnt = !match ? 4'd1 : (cnt[sel] >= STABLE ? STABLE : cnt[sel] + 4'd1);
  assign commit  = one_hot && nxt_cnt == STABLE;
  assign cur_hex = digits[4*sel +: 4];
  assign chg     = commit && ((legal && hex != cur_hex) || legal != digit_vld[sel]);
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        cand[i] <= '0;
        cnt[i] <= '0;
      end
      digits <= '0;
      digit_vld <= '0;
      upd <= 1'b0;
      upd_idx <= '0;
      err <= 1'b0;
    end else begin
      err <= multi | (err & ~clr_err);
      upd <= chg;
      if (chg) upd_idx <= 3'(sel);
      if (one_hot) begin
        cand[sel] <= seg;
        cnt[sel] <= nxt_cnt;
        if (commit) begin
          if (legal) digits[4*sel +: 4] <= hex;
          digit_vld[sel] <= legal;
        end
      end
    end
  end
endmodule
